csel_pipe_subtractor: RTL and testbench
=======================================

Name: csel_pipe_subtractor

Overview:
- Two-stage pipelined WIDTH-bit subtractor. Computes diff = a - b - borrow_in using a carry-select structure: the low half ripples, and the high half is precomputed for both incoming carries.
- Counterpart to the combinational carry-select adder. Used in the SpMV datapath for index/offset differences (row_ptr[i+1]-row_ptr[i]) and signed compares.
- Valid/ready handshake on both sides. Full throughput of one result per cycle; stalls under backpressure without loss.

Parameters:
- WIDTH, 16, operand/result width (even, >=4)
- LO_W, WIDTH/2, low-half width resolved in stage 1; high half = WIDTH-LO_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- borrow_in  in  1  borrow into bit 0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- diff  out  WIDTH  (a - b - borrow_in) mod 2^WIDTH
- borrow_out  out  1  1 iff unsigned a < b + borrow_in
- zero  out  1  diff == 0
- neg  out  1  diff[WIDTH-1]
- ovf  out  1  signed overflow: a[msb]!=b[msb] && diff[msb]!=a[msb]

Behaviour:
- Arithmetic: a + ~b + ~borrow_in, so carry-in = ~borrow_in and borrow_out = ~carry_out. No sign extension; all widths are exact.
- Stage 1 (on accept):
  - Register low-half diff and low carry c_lo.
  - Register high-half sum/carry for both cases: {h0,c0} assuming carry-in 0, {h1,c1} assuming carry-in 1.
  - Register a[msb] and b[msb].
- Stage 2 (on advance):
  - Select the high half by c_lo: diff = {c_lo?h1:h0, lo}; carry = c_lo?c1:c0.
  - Compute flags from the selected result and register all outputs.
- Latency: 2 cycles from accepted input to out_valid, with no stall.
- Handshake:
  - s2_free = ~out_valid | out_ready
  - in_ready = ~s1_valid | s2_free
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Stage 1 moves to stage 2 when s1_valid & s2_free.
  - s1_valid set on input transfer; cleared when stage 1 moves with no new input.
  - in_ready is combinational from out_ready; no other comb input-to-output paths.
- Stall: while out_valid & ~out_ready, diff and all flags hold stable; stage 1 holds if full. With both stages full, in_ready=0.
- Simultaneous input transfer, stage-1 move and output transfer in one cycle is legal; sustains 1 result/cycle.
- Operands and borrow_in are sampled only on input transfer; changes while in_ready=0 are ignored.
- Reset: s1_valid=0, out_valid=0, in_ready=1 (comb), diff=0, borrow_out=0, zero=0, neg=0, ovf=0. Stage-1 data registers also clear to 0.
- Reset asserted mid-operation drops all in-flight results; no output transfer follows.
- Boundary: a==b with borrow_in=1 gives diff=all-ones, borrow_out=1. 0-0 gives zero=1. Carry crossing the LO_W boundary is resolved only via the stage-2 select.

Decomposition:
- Shared package/header holds: DEFAULT_WIDTH=16; a function or macro for the signed-overflow rule, reused by the future comparator.
- One sub-module: csel_half_sub #(W). Pure combinational ripple of full adders taking x, y_inv and cin, returning {sum, cout}.
- Instantiated three times: low half with cin=~borrow_in; high half with cin=0 and with cin=1.
- The full adder and 2:1 mux cells already in the codebase are reused inside it.

Test Plan:
- a=0x1234, b=0x0234, bin=0, out_ready=1 -> after 2 cycles diff=0x1000, borrow_out=0, zero=0, neg=0, ovf=0.
- a=0x0100, b=0x0001 (borrow crosses the half boundary) -> diff=0x00FF, borrow_out=0. Then a=0x0000, b=0x0001 -> diff=0xFFFF, borrow_out=1, neg=1, ovf=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, neg=0, borrow_out=0. Then a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1.
- Stream 8 back-to-back vectors with out_ready held 0 for cycles 3-6:
  - in_ready drops to 0 once 2 results are buffered.
  - Outputs stay stable while stalled.
  - All 8 results emerge in order, with none lost or duplicated.
- Assert rst_n low for 1 cycle with both stages full -> out_valid=0 and diff=0 immediately. The next accepted vector appears exactly 2 cycles after acceptance.
- Random 10k vectors with random in_valid/out_ready, compared against the reference model {bout,diff} = {1'b0,a} - b - bin, with flags checked. Also run with WIDTH=32.

Source files
------------

// File: rtl/csel_pipe_subtractor_pkg.sv
// Shared definitions for the carry-select pipelined subtractor and its future
// comparator sibling: default width, full-adder cell and signed-overflow rule.
package csel_pipe_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Two's-complement overflow of a - b: operand signs differ and the result sign left a's sign.
    function automatic logic sub_signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    // Full-adder cell returning {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

endpackage

// File: rtl/csel_half_sub.sv
// Combinational ripple of full adders computing x + y_inv + cin; the caller
// supplies the already-inverted subtrahend so this block is a plain adder.
module csel_half_sub
    import csel_pipe_subtractor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_inv_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] carry_s;

    assign carry_s[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign {carry_s[i+1], sum_o[i]} = full_add(x_i[i], y_inv_i[i], carry_s[i]);
    end

    assign cout_o = carry_s[W];

endmodule

// File: rtl/csel_pipe_subtractor.sv
// Two-stage pipelined subtractor: stage 1 ripples the low half and precomputes
// the high half for both carries, stage 2 selects by the low carry and forms flags.
module csel_pipe_subtractor
    import csel_pipe_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int HI_W = WIDTH - LO_W;

    // Stage-1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [LO_W-1:0]  lo_q, lo_d;
    logic             c_lo_q, c_lo_d;
    logic [HI_W-1:0]  h0_q, h0_d, h1_q, h1_d;
    logic             c0_q, c0_d, c1_q, c1_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;

    // Stage-2 (output) registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

    logic [LO_W-1:0]  lo_sum_s;
    logic             lo_cout_s;
    logic [HI_W-1:0]  h0_sum_s, h1_sum_s;
    logic             h0_cout_s, h1_cout_s;
    logic             s2_free_s, in_fire_s, s1_move_s;
    logic [HI_W-1:0]  hi_sel_s;
    logic             carry_sel_s;
    logic [WIDTH-1:0] diff_sel_s;

    // Subtraction as a + ~b + ~borrow_in, so borrow_out is the inverted carry out.
    csel_half_sub #(.W(LO_W)) u_lo (
        .x_i     (a[LO_W-1:0]),
        .y_inv_i (~b[LO_W-1:0]),
        .cin_i   (~borrow_in),
        .sum_o   (lo_sum_s),
        .cout_o  (lo_cout_s)
    );

    csel_half_sub #(.W(HI_W)) u_hi0 (
        .x_i     (a[WIDTH-1:LO_W]),
        .y_inv_i (~b[WIDTH-1:LO_W]),
        .cin_i   (1'b0),
        .sum_o   (h0_sum_s),
        .cout_o  (h0_cout_s)
    );

    csel_half_sub #(.W(HI_W)) u_hi1 (
        .x_i     (a[WIDTH-1:LO_W]),
        .y_inv_i (~b[WIDTH-1:LO_W]),
        .cin_i   (1'b1),
        .sum_o   (h1_sum_s),
        .cout_o  (h1_cout_s)
    );

    assign s2_free_s = ~out_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s2_free_s;
    assign in_fire_s = in_valid & in_ready;
    assign s1_move_s = s1_valid_q & s2_free_s;

    // High-half select by the low carry; the only place a carry crosses the half boundary.
    always_comb begin
        hi_sel_s    = c_lo_q ? h1_q : h0_q;
        carry_sel_s = c_lo_q ? c1_q : c0_q;
        diff_sel_s  = {hi_sel_s, lo_q};
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        lo_d         = lo_q;
        c_lo_d       = c_lo_q;
        h0_d         = h0_q;
        c0_d         = c0_q;
        h1_d         = h1_q;
        c1_d         = c1_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        out_valid_d  = out_valid_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;

        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            lo_d       = lo_sum_s;
            c_lo_d     = lo_cout_s;
            h0_d       = h0_sum_s;
            c0_d       = h0_cout_s;
            h1_d       = h1_sum_s;
            c1_d       = h1_cout_s;
            a_msb_d    = a[WIDTH-1];
            b_msb_d    = b[WIDTH-1];
        end else if (s1_move_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s1_move_s) begin
            out_valid_d  = 1'b1;
            diff_d       = diff_sel_s;
            borrow_out_d = ~carry_sel_s;
            zero_d       = (diff_sel_s == {WIDTH{1'b0}});
            neg_d        = diff_sel_s[WIDTH-1];
            ovf_d        = sub_signed_ovf(a_msb_q, b_msb_q, diff_sel_s[WIDTH-1]);
        end else if (s2_free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            lo_q         <= {LO_W{1'b0}};
            c_lo_q       <= 1'b0;
            h0_q         <= {HI_W{1'b0}};
            c0_q         <= 1'b0;
            h1_q         <= {HI_W{1'b0}};
            c1_q         <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            diff_q       <= {WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            lo_q         <= lo_d;
            c_lo_q       <= c_lo_d;
            h0_q         <= h0_d;
            c0_q         <= c0_d;
            h1_q         <= h1_d;
            c1_q         <= c1_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            out_valid_q  <= out_valid_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;
    assign neg        = neg_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_csel_pipe_subtractor.sv
// Directed bench for csel_pipe_subtractor: single vectors with hand-computed
// results, a stalled 8-deep stream, mid-flight reset and a random scoreboard burst.
module tb_csel_pipe_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow_out;
    logic        zero;
    logic        neg;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    csel_pipe_subtractor #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one vector, expect it two edges later with out_ready held high.
    task automatic single(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin, input logic [15:0] ed, input logic eb,
                          input logic ez, input logic en, input logic eo);
        @(negedge clk);
        a = va; b = vb; borrow_in = vbin; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; borrow_in = 1'b1;
        @(negedge clk);
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_diff"},  {16'd0, diff}, {16'd0, ed});
        chk({tag, "_bout"},  {31'd0, borrow_out}, {31'd0, eb});
        chk({tag, "_zero"},  {31'd0, zero}, {31'd0, ez});
        chk({tag, "_neg"},   {31'd0, neg}, {31'd0, en});
        chk({tag, "_ovf"},   {31'd0, ovf}, {31'd0, eo});
    endtask

    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        sbin [8];
    logic [15:0] sd [8];
    logic        sbo [8];
    logic [16:0] exp_q [$];

    initial begin
        int sent;
        int recv;
        int cyc;
        logic hs_in;
        logic hs_out;
        logic [16:0] ref_v;
        logic [16:0] got;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'h0000; b = 16'h0000; borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_diff",      {16'd0, diff}, 32'd0);
        chk("rst_flags",     {28'd0, borrow_out, zero, neg, ovf}, 32'd0);
        rst_n = 1'b1;

        single("basic",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        single("cross",     16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        single("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        single("sovf_pos",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        single("zero_bin",  16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        single("eq_bin",    16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        single("zz",        16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        single("sovf_neg",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

        // Stream of 8 with output stalled during cycles 3..6.
        sa[0]=16'h0005; sb[0]=16'h0003; sbin[0]=1'b0; sd[0]=16'h0002; sbo[0]=1'b0;
        sa[1]=16'h0100; sb[1]=16'h0001; sbin[1]=1'b0; sd[1]=16'h00FF; sbo[1]=1'b0;
        sa[2]=16'h0000; sb[2]=16'h0000; sbin[2]=1'b1; sd[2]=16'hFFFF; sbo[2]=1'b1;
        sa[3]=16'hABCD; sb[3]=16'h0BCD; sbin[3]=1'b0; sd[3]=16'hA000; sbo[3]=1'b0;
        sa[4]=16'h8000; sb[4]=16'h8000; sbin[4]=1'b0; sd[4]=16'h0000; sbo[4]=1'b0;
        sa[5]=16'hFFFF; sb[5]=16'h0001; sbin[5]=1'b1; sd[5]=16'hFFFD; sbo[5]=1'b0;
        sa[6]=16'h1234; sb[6]=16'h1111; sbin[6]=1'b0; sd[6]=16'h0123; sbo[6]=1'b0;
        sa[7]=16'h00FF; sb[7]=16'h00FF; sbin[7]=1'b1; sd[7]=16'hFFFF; sbo[7]=1'b1;
        sent = 0; recv = 0;
        for (cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3 && cyc <= 6) ? 1'b0 : 1'b1;
            in_valid  = (sent < 8) ? 1'b1 : 1'b0;
            if (sent < 8) begin
                a = sa[sent]; b = sb[sent]; borrow_in = sbin[sent];
            end
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_valid",    {31'd0, out_valid}, 32'd1);
                chk("stall_diff",     {16'd0, diff}, {16'd0, sd[1]});
            end
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            if (hs_out) begin
                chk($sformatf("stream_diff%0d", recv), {16'd0, diff}, {16'd0, sd[recv]});
                chk($sformatf("stream_bout%0d", recv), {31'd0, borrow_out}, {31'd0, sbo[recv]});
                recv++;
            end
            if (hs_in) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_count", recv, 32'd8);
        @(negedge clk);
        chk("stream_no_dup", {31'd0, out_valid}, 32'd0);

        // Fill both stages, then reset mid-flight.
        out_ready = 1'b0;
        a = 16'h0009; b = 16'h0001; borrow_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h0003; b = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_diff",     {16'd0, diff}, 32'h0008);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",    {31'd0, out_valid}, 32'd0);
        chk("mrst_diff",     {16'd0, diff}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_no_ghost", {31'd0, out_valid}, 32'd0);
        single("post_rst", 16'h0040, 16'h0004, 1'b0, 16'h003C, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random burst against a {1'b0,a} - b - bin reference model.
        sent = 0; recv = 0;
        for (cyc = 0; cyc < 3000 && recv < 300; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_valid  = (sent < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom_range(0, 1));
            #1;
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            if (hs_out) begin
                got = {borrow_out, diff};
                chk("rnd_result", {15'd0, got}, {15'd0, exp_q[0]});
                chk("rnd_zero", {31'd0, zero}, {31'd0, exp_q[0][15:0] == 16'h0000});
                chk("rnd_neg",  {31'd0, neg},  {31'd0, exp_q[0][15]});
                void'(exp_q.pop_front());
                recv++;
            end
            if (hs_in) begin
                ref_v = {1'b0, a} - {1'b0, b} - {16'd0, borrow_in};
                exp_q.push_back(ref_v);
                sent++;
            end
        end
        chk("rnd_count", recv, 32'd300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
